// File: rtl/seq_event_counter_if.sv
// Bus between the sequence detector and the event statistics counter.
// Optional ovf signal is present only when SEQ_CNT_OVF_EN is defined.
interface seq_event_counter_if #(
    parameter int unsigned CNT_W = 8
);
    logic             Z;
    logic             W_q;
    logic             clr;
    logic [CNT_W-1:0] ones_cnt;
    logic [CNT_W-1:0] zeros_cnt;
    logic [CNT_W-1:0] run_len;
    logic [CNT_W-1:0] max_run;
    logic             event_pulse;
    logic             busy;
`ifdef SEQ_CNT_OVF_EN
    logic             ovf;

    modport master (
        output Z, W_q, clr,
        input  ones_cnt, zeros_cnt, run_len, max_run, event_pulse, busy, ovf
    );

    modport slave (
        input  Z, W_q, clr,
        output ones_cnt, zeros_cnt, run_len, max_run, event_pulse, busy, ovf
    );
`else
    modport master (
        output Z, W_q, clr,
        input  ones_cnt, zeros_cnt, run_len, max_run, event_pulse, busy
    );

    modport slave (
        input  Z, W_q, clr,
        output ones_cnt, zeros_cnt, run_len, max_run, event_pulse, busy
    );
`endif
endinterface

// File: rtl/seq_event_counter.sv
// Counts runs of ones/zeros flagged by a four-in-a-row detector, tracking run length and longest run.
// Define SEQ_CNT_OVF_EN to add the sticky saturation flag ovf.
module seq_event_counter #(
    parameter int unsigned CNT_W = 8
) (
    input  logic                clk,
    input  logic                reset,
    seq_event_counter_if.slave  bus
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RUN_ONE  = 2'd1,
        RUN_ZERO = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] ones_q;
    logic [CNT_W-1:0] ones_nxt;
    logic [CNT_W-1:0] zeros_q;
    logic [CNT_W-1:0] zeros_nxt;
    logic [CNT_W-1:0] len_q;
    logic [CNT_W-1:0] len_nxt;
    logic [CNT_W-1:0] max_q;
    logic [CNT_W-1:0] max_nxt;
    logic             evt_q;
    logic             evt_nxt;
    logic             busy_q;
    logic             busy_nxt;
    logic             new_det;
    logic             cont;

    // State register and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            ones_q  <= '0;
            zeros_q <= '0;
            len_q   <= '0;
            max_q   <= '0;
            evt_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state   <= state_nxt;
            ones_q  <= ones_nxt;
            zeros_q <= zeros_nxt;
            len_q   <= len_nxt;
            max_q   <= max_nxt;
            evt_q   <= evt_nxt;
            busy_q  <= busy_nxt;
        end
    end

    // Next state and next register values
    always_comb begin
        state_nxt = state;
        new_det   = 1'b0;
        cont      = 1'b0;
        ones_nxt  = ones_q;
        zeros_nxt = zeros_q;
        len_nxt   = '0;
        max_nxt   = max_q;
        evt_nxt   = 1'b0;
        busy_nxt  = 1'b0;

        case (state)
            IDLE: begin
                if (bus.Z) begin
                    new_det   = 1'b1;
                    state_nxt = bus.W_q ? RUN_ONE : RUN_ZERO;
                end
            end
            RUN_ONE: begin
                if (!bus.Z) begin
                    state_nxt = IDLE;
                end else if (!bus.W_q) begin
                    new_det   = 1'b1;
                    state_nxt = RUN_ZERO;
                end else begin
                    cont = 1'b1;
                end
            end
            RUN_ZERO: begin
                if (!bus.Z) begin
                    state_nxt = IDLE;
                end else if (bus.W_q) begin
                    new_det   = 1'b1;
                    state_nxt = RUN_ONE;
                end else begin
                    cont = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase

        // A polarity switch counts as a fresh detection and restarts the run
        if (new_det) begin
            len_nxt = CNT_ONE;
            evt_nxt = 1'b1;
            if (bus.W_q) begin
                if (ones_q != CNT_MAX) ones_nxt = ones_q + CNT_ONE;
            end else begin
                if (zeros_q != CNT_MAX) zeros_nxt = zeros_q + CNT_ONE;
            end
        end else if (cont) begin
            len_nxt = (len_q != CNT_MAX) ? len_q + CNT_ONE : len_q;
        end

        if (len_nxt > max_q) max_nxt = len_nxt;

        // clr wins over same-cycle increments but leaves the run itself alone
        if (bus.clr) begin
            ones_nxt  = '0;
            zeros_nxt = '0;
            max_nxt   = '0;
        end

        busy_nxt = (state_nxt != IDLE);
    end

`ifdef SEQ_CNT_OVF_EN
    logic ovf_q;
    logic sat_hit;

    // Any increment attempted at full scale
    assign sat_hit = (new_det &&  bus.W_q && (ones_q  == CNT_MAX))
                  || (new_det && !bus.W_q && (zeros_q == CNT_MAX))
                  || (cont && (len_q == CNT_MAX));

    always_ff @(posedge clk) begin
        if (reset) begin
            ovf_q <= 1'b0;
        end else if (bus.clr) begin
            ovf_q <= 1'b0;
        end else if (sat_hit) begin
            ovf_q <= 1'b1;
        end
    end

    assign bus.ovf = ovf_q;
`endif

    assign bus.ones_cnt    = ones_q;
    assign bus.zeros_cnt   = zeros_q;
    assign bus.run_len     = len_q;
    assign bus.max_run     = max_q;
    assign bus.event_pulse = evt_q;
    assign bus.busy        = busy_q;

endmodule

// File: tb/tb_seq_event_counter.sv
// Self-checking bench for seq_event_counter: directed scenarios plus randomized traffic vs. a reference model.
// Checks ovf too when SEQ_CNT_OVF_EN is defined.
module tb_seq_event_counter;

    localparam int unsigned CNT_W = 4;
    localparam int          CMAX  = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   failures = 0;

    // Reference model state: plain integers driven by the run rules
    int m_ones, m_zeros, m_len, m_max, m_evt, m_ovf;
    bit m_active, m_pol;

    seq_event_counter_if #(.CNT_W(CNT_W)) bus ();

    seq_event_counter #(.CNT_W(CNT_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic model_step(input bit z, input bit w, input bit c, input bit r);
        bit det;
        bit same;
        if (r) begin
            m_active = 0; m_pol = 0;
            m_ones = 0; m_zeros = 0; m_len = 0; m_max = 0; m_evt = 0; m_ovf = 0;
        end else begin
            det  = z && (!m_active || (m_pol != w));
            same = z && m_active && (m_pol == w);
            m_evt = det ? 1 : 0;
            if (det) begin
                m_len = 1;
                if (w) begin
                    if (m_ones == CMAX) m_ovf = 1; else m_ones++;
                end else begin
                    if (m_zeros == CMAX) m_ovf = 1; else m_zeros++;
                end
            end else if (same) begin
                if (m_len == CMAX) m_ovf = 1; else m_len++;
            end else begin
                m_len = 0;
            end
            m_active = z;
            m_pol    = w;
            if (m_len > m_max) m_max = m_len;
            if (c) begin
                m_ones = 0; m_zeros = 0; m_max = 0; m_ovf = 0;
            end
        end
    endtask

    task automatic tick(input bit z, input bit w, input bit c, input bit r);
        bus.Z   = z;
        bus.W_q = w;
        bus.clr = c;
        reset   = r;
        @(posedge clk);
        model_step(z, w, c, r);
        #1;
    endtask

    task automatic test_reset();
        tick(1, 1, 1, 1);
        tick(0, 0, 0, 1);
        checks++;
        if (bus.ones_cnt !== 0 || bus.zeros_cnt !== 0 || bus.run_len !== 0 || bus.max_run !== 0
            || bus.event_pulse !== 1'b0 || bus.busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_state got ones=%0d zeros=%0d len=%0d max=%0d evt=%0b busy=%0b expected all 0",
                     bus.ones_cnt, bus.zeros_cnt, bus.run_len, bus.max_run, bus.event_pulse, bus.busy);
        end
`ifdef SEQ_CNT_OVF_EN
        checks++;
        if (bus.ovf !== 1'b0) begin
            failures++;
            $display("FAIL reset_ovf got %0b expected 0", bus.ovf);
        end
`endif
    endtask

    task automatic test_ones_run();
        tick(0, 0, 0, 1);
        tick(1, 1, 0, 0);
        checks++;
        if (bus.event_pulse !== 1'b1 || bus.ones_cnt !== 1 || bus.run_len !== 1 || bus.busy !== 1'b1) begin
            failures++;
            $display("FAIL ones_run.first got evt=%0b ones=%0d len=%0d busy=%0b expected 1/1/1/1",
                     bus.event_pulse, bus.ones_cnt, bus.run_len, bus.busy);
        end
        tick(1, 1, 0, 0);
        checks++;
        if (bus.event_pulse !== 1'b0 || bus.run_len !== 2) begin
            failures++;
            $display("FAIL ones_run.second got evt=%0b len=%0d expected 0/2", bus.event_pulse, bus.run_len);
        end
        tick(1, 1, 0, 0);
        checks++;
        if (bus.run_len !== 3 || bus.max_run !== 3 || bus.ones_cnt !== 1) begin
            failures++;
            $display("FAIL ones_run.third got len=%0d max=%0d ones=%0d expected 3/3/1",
                     bus.run_len, bus.max_run, bus.ones_cnt);
        end
        tick(0, 0, 0, 0);
        checks++;
        if (bus.busy !== 1'b0 || bus.run_len !== 0 || bus.max_run !== 3 || bus.ones_cnt !== 1
            || bus.zeros_cnt !== 0) begin
            failures++;
            $display("FAIL ones_run.end got busy=%0b len=%0d max=%0d ones=%0d zeros=%0d expected 0/0/3/1/0",
                     bus.busy, bus.run_len, bus.max_run, bus.ones_cnt, bus.zeros_cnt);
        end
    endtask

    task automatic test_polarity_switch();
        int pulses = 0;
        tick(0, 0, 0, 1);
        for (int i = 0; i < 5; i++) begin
            tick(1, 0, 0, 0);
            pulses += int'(bus.event_pulse);
        end
        for (int i = 0; i < 2; i++) begin
            tick(1, 1, 0, 0);
            pulses += int'(bus.event_pulse);
        end
        checks++;
        if (bus.zeros_cnt !== 1 || bus.ones_cnt !== 1 || bus.max_run !== 5 || bus.run_len !== 2
            || pulses != 2) begin
            failures++;
            $display("FAIL polarity_switch got zeros=%0d ones=%0d max=%0d len=%0d pulses=%0d expected 1/1/5/2/2",
                     bus.zeros_cnt, bus.ones_cnt, bus.max_run, bus.run_len, pulses);
        end
    endtask

    task automatic test_saturation();
        tick(0, 0, 0, 1);
        for (int i = 0; i < 17; i++) begin
            tick(1, 1, 0, 0);
            tick(0, 0, 0, 0);
            if (i == 14) begin
                checks++;
                if (bus.ones_cnt !== 4'(CMAX)) begin
                    failures++;
                    $display("FAIL sat.at_max got ones=%0d expected %0d", bus.ones_cnt, CMAX);
                end
`ifdef SEQ_CNT_OVF_EN
                checks++;
                if (bus.ovf !== 1'b0) begin
                    failures++;
                    $display("FAIL sat.ovf_early got %0b expected 0", bus.ovf);
                end
`endif
            end
        end
        checks++;
        if (bus.ones_cnt !== 4'(CMAX)) begin
            failures++;
            $display("FAIL sat.hold got ones=%0d expected %0d", bus.ones_cnt, CMAX);
        end
`ifdef SEQ_CNT_OVF_EN
        checks++;
        if (bus.ovf !== 1'b1) begin
            failures++;
            $display("FAIL sat.ovf got %0b expected 1", bus.ovf);
        end
`endif
        // Long run saturates run_len and max_run
        tick(0, 0, 0, 1);
        for (int i = 0; i < 20; i++) tick(1, 0, 0, 0);
        checks++;
        if (bus.run_len !== 4'(CMAX) || bus.max_run !== 4'(CMAX) || bus.zeros_cnt !== 1) begin
            failures++;
            $display("FAIL sat.run_len got len=%0d max=%0d zeros=%0d expected %0d/%0d/1",
                     bus.run_len, bus.max_run, bus.zeros_cnt, CMAX, CMAX);
        end
`ifdef SEQ_CNT_OVF_EN
        tick(1, 0, 1, 0);
        checks++;
        if (bus.ovf !== 1'b0) begin
            failures++;
            $display("FAIL sat.ovf_clr got %0b expected 0", bus.ovf);
        end
`endif
    endtask

    task automatic test_clr_collision();
        tick(0, 0, 0, 1);
        tick(1, 0, 0, 0);
        tick(1, 0, 0, 0);
        tick(0, 0, 0, 0);
        tick(1, 0, 1, 0);
        checks++;
        if (bus.zeros_cnt !== 0 || bus.max_run !== 0 || bus.event_pulse !== 1'b1 || bus.run_len !== 1
            || bus.busy !== 1'b1) begin
            failures++;
            $display("FAIL clr_collision got zeros=%0d max=%0d evt=%0b len=%0d busy=%0b expected 0/0/1/1/1",
                     bus.zeros_cnt, bus.max_run, bus.event_pulse, bus.run_len, bus.busy);
        end
        tick(1, 0, 0, 0);
        checks++;
        if (bus.run_len !== 2 || bus.max_run !== 2 || bus.zeros_cnt !== 0) begin
            failures++;
            $display("FAIL clr_after got len=%0d max=%0d zeros=%0d expected 2/2/0",
                     bus.run_len, bus.max_run, bus.zeros_cnt);
        end
    endtask

    task automatic test_reset_midrun();
        tick(0, 0, 0, 1);
        tick(1, 1, 0, 0);
        tick(1, 1, 0, 0);
        tick(1, 1, 0, 1);
        checks++;
        if (bus.ones_cnt !== 0 || bus.run_len !== 0 || bus.max_run !== 0 || bus.event_pulse !== 1'b0
            || bus.busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_midrun got ones=%0d len=%0d max=%0d evt=%0b busy=%0b expected all 0",
                     bus.ones_cnt, bus.run_len, bus.max_run, bus.event_pulse, bus.busy);
        end
        tick(1, 1, 0, 0);
        checks++;
        if (bus.ones_cnt !== 1 || bus.event_pulse !== 1'b1 || bus.run_len !== 1 || bus.busy !== 1'b1) begin
            failures++;
            $display("FAIL reset_release got ones=%0d evt=%0b len=%0d busy=%0b expected 1/1/1/1",
                     bus.ones_cnt, bus.event_pulse, bus.run_len, bus.busy);
        end
    endtask

    task automatic test_random();
        bit z;
        bit w = 1'b0;
        bit c;
        bit r;
        tick(0, 0, 0, 1);
        for (int i = 0; i < 600; i++) begin
            z = ($urandom_range(0, 9) < 8);
            if ($urandom_range(0, 3) == 0) w = ~w;
            c = ($urandom_range(0, 29) == 0);
            r = ($urandom_range(0, 79) == 0);
            tick(z, w, c, r);
            checks++;
            if (bus.ones_cnt !== 4'(m_ones) || bus.zeros_cnt !== 4'(m_zeros) || bus.run_len !== 4'(m_len)
                || bus.max_run !== 4'(m_max) || bus.event_pulse !== 1'(m_evt) || bus.busy !== m_active) begin
                failures++;
                $display("FAIL random[%0d] got ones=%0d zeros=%0d len=%0d max=%0d evt=%0b busy=%0b expected %0d/%0d/%0d/%0d/%0d/%0b",
                         i, bus.ones_cnt, bus.zeros_cnt, bus.run_len, bus.max_run, bus.event_pulse, bus.busy,
                         m_ones, m_zeros, m_len, m_max, m_evt, m_active);
            end
`ifdef SEQ_CNT_OVF_EN
            checks++;
            if (bus.ovf !== 1'(m_ovf)) begin
                failures++;
                $display("FAIL random_ovf[%0d] got %0b expected %0d", i, bus.ovf, m_ovf);
            end
`endif
        end
    endtask

    initial begin
        reset   = 1'b1;
        bus.Z   = 1'b0;
        bus.W_q = 1'b0;
        bus.clr = 1'b0;
        test_reset();
        test_ones_run();
        test_polarity_switch();
        test_saturation();
        test_clr_collision();
        test_reset_midrun();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/seq_event_counter.md
SEQ_EVENT_COUNTER -- requirements
Module: seq_event_counter

Interface
REQ-001 The block SHALL have one parameter: CNT_W, default 8, width of every counter output.
REQ-002 The block SHALL have port clk, input, 1, the only clock; all state updates on its rising edge.
REQ-003 The block SHALL have port reset, input, 1; reset is synchronous and active-high.
REQ-004 The block SHALL have port Z, input, 1: detection flag from the upstream four-in-a-row sequence detector.
REQ-005 The block SHALL have port W_q, input, 1: the detector's newest registered sample (its ones-register bit 1), which identifies the run polarity.
REQ-006 The block SHALL have port clr, input, 1: synchronous clear of the statistics.
REQ-007 The block SHALL have ports ones_cnt and zeros_cnt, each output, CNT_W: count of detected runs of ones and of zeros.
REQ-008 The block SHALL have port run_len, output, CNT_W: length in cycles of the current detection run.
REQ-009 The block SHALL have port max_run, output, CNT_W: longest run_len seen since the last reset or clr.
REQ-010 The block SHALL have port event_pulse, output, 1: one-cycle pulse per new detection.
REQ-011 The block SHALL have port busy, output, 1: high while the FSM is in RUN_ONE or RUN_ZERO.

Function
REQ-012 The FSM SHALL have states IDLE, RUN_ONE and RUN_ZERO; all outputs SHALL be registered.
REQ-013 From IDLE, when Z=1 and W_q=1, the FSM SHALL go to RUN_ONE; when Z=1 and W_q=0, it SHALL go to RUN_ZERO; when Z=0, it SHALL stay in IDLE.
REQ-014 From RUN_ONE or RUN_ZERO, when Z=0, the FSM SHALL return to IDLE and run_len SHALL go to 0.
REQ-015 In RUN_ONE with Z=1 and W_q=0 (or in RUN_ZERO with Z=1 and W_q=1), the FSM SHALL treat this as a new detection of the opposite polarity and switch state.
REQ-016 On every new detection edge, the matching count (ones_cnt or zeros_cnt) SHALL increment by 1, event_pulse SHALL be 1 for exactly the following cycle, and run_len SHALL load 1.
REQ-017 While a run continues (Z=1, same polarity), run_len SHALL increment by 1 each cycle.
REQ-018 max_run SHALL load run_len's next value whenever that value exceeds max_run, in the same edge.
REQ-019 Latency: a Z edge sampled at clock edge N SHALL be visible on all outputs after edge N.
REQ-020 All counters SHALL saturate at 2^CNT_W-1 and never wrap.
REQ-021 clr=1 SHALL zero ones_cnt, zeros_cnt and max_run at the next edge.
REQ-022 clr SHALL not affect the FSM state, run_len or busy.
REQ-023 When clr and a detection occur in the same cycle, clr SHALL win for the counters (they read 0), while event_pulse, the state change and run_len=1 SHALL still occur.
REQ-024 busy SHALL equal (state != IDLE).

Reset
REQ-025 On reset=1 at a clock edge, the state SHALL go to IDLE and every output SHALL go to 0, including ovf when present.
REQ-026 Reset mid-run SHALL abandon the run without counting it again; after release, a still-high Z SHALL be treated as a new detection from IDLE.
REQ-027 Reset SHALL have priority over clr and over all inputs.

Configuration
REQ-028 With macro SEQ_CNT_OVF_EN defined, the block SHALL have an extra output ovf (1 bit), set sticky when any counter attempts to increment while at saturation.
REQ-029 ovf SHALL be cleared only by reset or clr.
REQ-030 Without SEQ_CNT_OVF_EN defined, the ovf port and its logic SHALL be absent, and saturation behaviour SHALL be unchanged.

Verification
REQ-031 After reset, drive Z=1 with W_q=1 for 3 cycles, then Z=0 -> ones_cnt=1, run_len reaches 3, max_run=3, event_pulse high for 1 cycle, busy returns to 0.
REQ-032 Drive Z=1 with W_q=0 for 5 cycles, then Z=1 with W_q=1 for 2 cycles -> zeros_cnt=1, ones_cnt=1, two event_pulses, max_run=5, run_len=2.
REQ-033 With CNT_W=4, perform 17 one-detections -> ones_cnt holds at 15; ovf=1 with SEQ_CNT_OVF_EN defined, port absent without it.
REQ-034 Assert clr in the same cycle as a new zero-detection -> zeros_cnt=0, max_run=0, event_pulse=1, run_len=1, busy=1.
REQ-035 Assert reset in the 3rd cycle of a run while Z stays 1 -> all outputs 0; on the first edge after release, the matching count=1 and event_pulse=1.
